pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a one-entry skid buffer, flush/stall control and saturating
// stall/bubble performance counters.
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned CNT_W      = 16,
  parameter bit          FLUSH_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  input  logic              i_stall,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic                accept, xfer;

  assign o_ready = (state_q != StTwo) && !i_stall && !i_flush;
  assign o_valid = (state_q != StEmpty) && !i_stall;
  assign accept  = i_valid && o_ready;
  assign xfer    = o_valid && i_ready;

  assign o_ctrl       = main_ctrl_q;
  assign o_data       = main_data_q;
  assign o_stall_cnt  = stall_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (i_flush) begin
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (FLUSH_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      // Stall forces accept and xfer low, so every case below simply holds.
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StOne;
            main_ctrl_d = i_ctrl;
            main_data_d = i_data;
          end
        end
        StOne: begin
          if (accept && xfer) begin
            main_ctrl_d = i_ctrl;
            main_data_d = i_data;
          end else if (accept) begin
            state_d     = StTwo;
            skid_ctrl_d = i_ctrl;
            skid_data_d = i_data;
          end else if (xfer) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
          end
        end
        StTwo: begin
          if (xfer) begin
            state_d     = StOne;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (i_stall && !i_flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((state_q == StEmpty) && !i_stall && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StEmpty;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic, checked against a
// queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W     = 128;
  localparam int unsigned CTRL_W     = 16;
  localparam int unsigned CNT_W      = 4;
  localparam bit          FLUSH_DATA = 1'b1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_valid = 1'b0, i_flush = 1'b0, i_stall = 1'b0, i_ready = 1'b0;
  logic [CTRL_W-1:0] i_ctrl = '0;
  logic [DATA_W-1:0] i_data = '0;
  logic              o_ready, o_valid;
  logic [CTRL_W-1:0] o_ctrl;
  logic [DATA_W-1:0] o_data;
  logic [CNT_W-1:0]  o_stall_cnt, o_bubble_cnt;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .FLUSH_DATA(FLUSH_DATA)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl),
    .i_data(i_data), .i_flush(i_flush), .i_stall(i_stall), .o_valid(o_valid),
    .i_ready(i_ready), .o_ctrl(o_ctrl), .o_data(o_data), .o_stall_cnt(o_stall_cnt),
    .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Model: ordered list of held entries, payload left visible when empty, counters.
  entry_t      q[$];
  logic [DATA_W-1:0] empty_data;
  int          m_stall, m_bubble;
  int          tests = 0;
  int          fails = 0;
  localparam int CntMax = (1 << CNT_W) - 1;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    empty_data = '0;
    m_stall    = 0;
    m_bubble   = 0;
  endtask

  // Drive one cycle: apply inputs, compare outputs mid-cycle, advance model, clock.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic fl, input logic st, input logic rd);
    int     n;
    logic   m_ready, m_valid, acc, rel;
    entry_t e, popped;
    i_valid = v; i_ctrl = c; i_data = d; i_flush = fl; i_stall = st; i_ready = rd;
    #1;
    n       = q.size();
    m_ready = (n < 2) && !st && !fl;
    m_valid = (n > 0) && !st;
    chk("o_ready", DATA_W'(o_ready), DATA_W'(m_ready));
    chk("o_valid", DATA_W'(o_valid), DATA_W'(m_valid));
    chk("o_ctrl", DATA_W'(o_ctrl), (n > 0) ? DATA_W'(q[0].ctrl) : '0);
    chk("o_data", o_data, (n > 0) ? q[0].data : empty_data);
    chk("o_stall_cnt", DATA_W'(o_stall_cnt), DATA_W'(m_stall));
    chk("o_bubble_cnt", DATA_W'(o_bubble_cnt), DATA_W'(m_bubble));
    acc = v && m_ready;
    rel = m_valid && rd;
    if (st && !fl && m_stall < CntMax) m_stall++;
    if (n == 0 && !st && m_bubble < CntMax) m_bubble++;
    if (fl) begin
      if (FLUSH_DATA) empty_data = '0;
      else if (n > 0) empty_data = q[0].data;
      q.delete();
    end else begin
      if (rel) begin
        popped = q.pop_front();
        if (q.size() == 0) empty_data = popped.data;
      end
      if (acc) begin
        e.ctrl = c;
        e.data = d;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] rd_data;
    model_reset();
    #1;
    chk("rst_valid", DATA_W'(o_valid), '0);
    chk("rst_ctrl", DATA_W'(o_ctrl), '0);
    chk("rst_data", o_data, '0);
    #6 reset = 1'b0;

    // Pass-through with first accept on the first edge after reset.
    step(1, 16'h0003, 'hA5, 0, 0, 1);
    chk("pt_valid", DATA_W'(o_valid), 1);
    chk("pt_ctrl", DATA_W'(o_ctrl), 'h3);
    chk("pt_data", o_data, 'hA5);
    step(0, '0, '0, 0, 0, 1);
    chk("pt_empty_ctrl", DATA_W'(o_ctrl), '0);
    step(0, '0, '0, 0, 0, 1);

    // Backpressure fills the skid, then drains in order.
    step(1, 16'h1, 'h1, 0, 0, 0);
    step(1, 16'h2, 'h2, 0, 0, 0);
    chk("bp_ready", DATA_W'(o_ready), '0);
    chk("bp_data", o_data, 'h1);
    step(0, '0, '0, 0, 0, 1);
    chk("bp_data2", o_data, 'h2);
    step(0, '0, '0, 0, 0, 1);
    chk("bp_drained", DATA_W'(o_valid), '0);

    // Flush while full with a same-cycle input.
    step(1, 16'h5, 'h5, 0, 0, 0);
    step(1, 16'h6, 'h6, 0, 0, 0);
    step(1, 16'h9, 'h9, 1, 0, 0);
    step(0, '0, '0, 0, 0, 1);
    chk("fl_ctrl", DATA_W'(o_ctrl), '0);
    chk("fl_data", o_data, '0);

    // Five stall cycles holding one entry.
    step(1, 16'h7, 'h7, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, '0, 0, 1, 1);
    chk("st_cnt", DATA_W'(o_stall_cnt), 5);
    chk("st_hold", o_data, 'h7);
    step(0, '0, '0, 0, 0, 1);

    // Bubble counter saturation.
    for (int i = 0; i < 20; i++) step(0, '0, '0, 0, 0, 1);
    chk("bub_sat", DATA_W'(o_bubble_cnt), CntMax);
    step(0, '0, '0, 0, 0, 1);
    chk("bub_hold", DATA_W'(o_bubble_cnt), CntMax);

    // Asynchronous reset between edges while full.
    step(1, 16'h11, 'h11, 0, 0, 0);
    step(1, 16'h12, 'h12, 0, 0, 0);
    i_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", DATA_W'(o_valid), '0);
    chk("ar_ctrl", DATA_W'(o_ctrl), '0);
    chk("ar_data", o_data, '0);
    chk("ar_stall", DATA_W'(o_stall_cnt), '0);
    chk("ar_bubble", DATA_W'(o_bubble_cnt), '0);
    model_reset();
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(9) < 7), CTRL_W'($urandom), rd_data, ($urandom_range(19) == 0),
           ($urandom_range(9) == 0), ($urandom_range(9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
